// File: rtl/timed_cmd_sched_pkg.sv
// Shared types for the timed-command scheduler: FSM state encoding and the stored command word.
package timed_cmd_pkg;

    localparam int unsigned CMD_TW = 64;
    localparam int unsigned CMD_PW = 274;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WRITE      = 3'd1,
        ST_SCAN       = 3'd2,
        ST_SCAN_FLUSH = 3'd3,
        ST_LOAD       = 3'd4,
        ST_ISSUE      = 3'd5
    } tcs_state_e;

    typedef struct packed {
        logic [CMD_TW-1:0] tstamp;
        logic [CMD_PW-1:0] payload;
    } cmd_t;

endpackage

// File: rtl/timed_cmd_sched_if.sv
// Command write / staged-command handshake bundle between the MCU side, scheduler and synchroniser.
interface timed_cmd_sched_if
    import timed_cmd_pkg::*;
#(
    parameter int unsigned TW = CMD_TW,
    parameter int unsigned PW = CMD_PW
);
    logic          wr_valid_i;
    logic          wr_ready_o;
    logic [TW-1:0] wr_time_i;
    logic [PW-1:0] wr_payload_i;
    logic          req_i;
    logic          cmd_valid_o;
    logic [TW-1:0] cmd_time_o;
    logic [PW-1:0] cmd_payload_o;
    logic          cmd_strobe_o;

    modport master (
        output wr_valid_i, wr_time_i, wr_payload_i, req_i,
        input  wr_ready_o, cmd_valid_o, cmd_time_o, cmd_payload_o, cmd_strobe_o
    );

    modport slave (
        input  wr_valid_i, wr_time_i, wr_payload_i, req_i,
        output wr_ready_o, cmd_valid_o, cmd_time_o, cmd_payload_o, cmd_strobe_o
    );
endinterface

// File: rtl/timed_cmd_sched_ram.sv
// Simple dual-port command RAM with registered read; maps onto block RAM.
module tcs_ram #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned W     = 338
) (
    input  logic                     CLK,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [W-1:0]             wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [W-1:0]             rdata_o
);
    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] rdata_q;

    always_ff @(posedge CLK) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/timed_cmd_sched.sv
// Timed-command scheduler: stores timestamped commands, stages the earliest future one, purges stale ones.
// Optional build macro TIMED_CMD_SCHED_AUTOISSUE_EN issues the staged command T_RESERVE ticks early without req_i.
module timed_cmd_sched
    import timed_cmd_pkg::*;
#(
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned TW        = CMD_TW,
    parameter int unsigned PW        = CMD_PW,
    parameter int unsigned T_RESERVE = 384
) (
    input  logic                   CLK,
    input  logic                   rst_n,
    input  logic [TW-1:0]          time_i,
    input  logic                   time_upd_i,
    timed_cmd_sched_if.slave       bus,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   ovf_o,
    input  logic                   clr_ovf_i,
    output logic                   busy_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned DW = TW + PW;

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("timed_cmd_sched: DEPTH must be a power of two >= 4");
    end
    if (T_RESERVE == 0 || (TW < 32 && (T_RESERVE >> TW) != 0)) begin : g_bad_reserve
        $error("timed_cmd_sched: T_RESERVE must be non-zero and fit in TW bits");
    end

    tcs_state_e       state_q, state_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             rescan_q, rescan_d;
    logic             upd_q;
    logic [AW-1:0]    wr_slot_q;
    logic [AW-1:0]    scan_addr_q, scan_addr_d;
    logic [AW-1:0]    cmp_addr_q;
    logic [AW-1:0]    winner_q, winner_d;
    logic [AW-1:0]    staged_q, staged_d;
    logic [TW-1:0]    min_q, min_d;
    logic             found_q, found_d;
    logic             cmd_valid_q, cmd_valid_d;
    logic [TW-1:0]    cmd_time_q, cmd_time_d;
    logic [PW-1:0]    cmd_payload_q, cmd_payload_d;
    logic             strobe_q, strobe_d;
    logic             busy_q, busy_d;

    logic [AW-1:0]    free_idx;
    logic [AW-1:0]    ram_raddr;
    logic [DW-1:0]    ram_rdata;
    logic [TW-1:0]    rd_time;
    logic [PW-1:0]    rd_payload;
    logic             full, auto_c, issue_go, accept, upd_rise;
    logic             cmp_en, cmp_hit, purge, better, scan_start;

`ifdef TIMED_CMD_SCHED_AUTOISSUE_EN
    assign auto_c = (TW'(cmd_time_q - time_i) <= TW'(T_RESERVE));
`else
    assign auto_c = 1'b0;
`endif

    assign full     = (count_q == CW'(DEPTH));
    assign issue_go = (state_q == ST_IDLE) && cmd_valid_q && (bus.req_i || auto_c);
    assign bus.wr_ready_o = (state_q == ST_IDLE) && !full && !issue_go;
    assign accept   = bus.wr_valid_i && bus.wr_ready_o;
    assign upd_rise = time_upd_i && !upd_q;

    // Lowest-index free slot
    always_comb begin
        free_idx = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (!valid_q[i]) free_idx = AW'(i);
        end
    end

    // Compare stage sees the RAM word read one cycle earlier
    assign rd_time    = ram_rdata[DW-1:PW];
    assign rd_payload = ram_rdata[PW-1:0];
    assign cmp_en     = ((state_q == ST_SCAN) && (scan_addr_q != '0)) || (state_q == ST_SCAN_FLUSH);
    assign cmp_hit    = cmp_en && valid_q[cmp_addr_q];
    assign purge      = cmp_hit && (rd_time <= time_i);
    assign better     = cmp_hit && !purge && (rd_time < min_q);

    tcs_ram #(.DEPTH(DEPTH), .W(DW)) u_ram (
        .CLK     (CLK),
        .we_i    (accept),
        .waddr_i (free_idx),
        .wdata_i ({bus.wr_time_i, bus.wr_payload_i}),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (issue_go)      state_d = ST_ISSUE;
                else if (accept)   state_d = ST_WRITE;
                else if (rescan_q) state_d = ST_SCAN;
            end
            ST_SCAN:       if (scan_addr_q == AW'(DEPTH - 1)) state_d = ST_SCAN_FLUSH;
            ST_SCAN_FLUSH: state_d = ST_LOAD;
            default:       state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        valid_d       = valid_q;
        count_d       = count_q;
        rescan_d      = rescan_q;
        scan_addr_d   = scan_addr_q;
        winner_d      = winner_q;
        min_d         = min_q;
        found_d       = found_q;
        staged_d      = staged_q;
        cmd_valid_d   = cmd_valid_q;
        cmd_time_d    = cmd_time_q;
        cmd_payload_d = cmd_payload_q;
        scan_start    = (state_q == ST_IDLE) && (state_d == ST_SCAN);

        ovf_d    = (bus.wr_valid_i && full) || (ovf_q && !clr_ovf_i);
        strobe_d = (state_d == ST_ISSUE);
        busy_d   = (state_d != ST_IDLE);

        if (scan_start) begin
            scan_addr_d = '0;
            min_d       = '1;
            found_d     = 1'b0;
            rescan_d    = 1'b0;
        end
        if (upd_rise || state_q == ST_WRITE || state_q == ST_ISSUE) rescan_d = 1'b1;

        if (state_q == ST_SCAN && scan_addr_q != AW'(DEPTH - 1)) scan_addr_d = scan_addr_q + AW'(1);
        if (better) begin
            winner_d = cmp_addr_q;
            min_d    = rd_time;
            found_d  = 1'b1;
        end
        if (purge) begin
            valid_d[cmp_addr_q] = 1'b0;
            count_d             = count_q - CW'(1);
        end

        case (state_q)
            ST_WRITE: begin
                valid_d[wr_slot_q] = 1'b1;
                count_d            = count_q + CW'(1);
            end
            ST_ISSUE: begin
                valid_d[staged_q] = 1'b0;
                count_d           = count_q - CW'(1);
                cmd_valid_d       = 1'b0;
            end
            ST_LOAD: begin
                cmd_valid_d = found_q;
                if (found_q) begin
                    cmd_time_d    = rd_time;
                    cmd_payload_d = rd_payload;
                    staged_d      = winner_q;
                end
            end
            default: ;
        endcase

        // During the flush cycle the winner's slot is re-read so LOAD sees its word
        ram_raddr = (state_q == ST_SCAN) ? scan_addr_q : winner_d;
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            valid_q       <= '0;
            count_q       <= '0;
            ovf_q         <= 1'b0;
            rescan_q      <= 1'b0;
            upd_q         <= 1'b0;
            wr_slot_q     <= '0;
            scan_addr_q   <= '0;
            cmp_addr_q    <= '0;
            winner_q      <= '0;
            staged_q      <= '0;
            min_q         <= '1;
            found_q       <= 1'b0;
            cmd_valid_q   <= 1'b0;
            cmd_time_q    <= '0;
            cmd_payload_q <= '0;
            strobe_q      <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            valid_q       <= valid_d;
            count_q       <= count_d;
            ovf_q         <= ovf_d;
            rescan_q      <= rescan_d;
            upd_q         <= time_upd_i;
            if (accept) wr_slot_q <= free_idx;
            scan_addr_q   <= scan_addr_d;
            cmp_addr_q    <= scan_addr_q;
            winner_q      <= winner_d;
            staged_q      <= staged_d;
            min_q         <= min_d;
            found_q       <= found_d;
            cmd_valid_q   <= cmd_valid_d;
            cmd_time_q    <= cmd_time_d;
            cmd_payload_q <= cmd_payload_d;
            strobe_q      <= strobe_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.cmd_valid_o   = cmd_valid_q;
    assign bus.cmd_time_o    = cmd_time_q;
    assign bus.cmd_payload_o = cmd_payload_q;
    assign bus.cmd_strobe_o  = strobe_q;
    assign count_o           = count_q;
    assign full_o            = full;
    assign ovf_o             = ovf_q;
    assign busy_o            = busy_q;
endmodule

// File: tb/tb_timed_cmd_sched.sv
// Directed bench for timed_cmd_sched (DEPTH=4); honours TIMED_CMD_SCHED_AUTOISSUE_EN.
module tb_timed_cmd_sched;
    import timed_cmd_pkg::*;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned TW     = 64;
    localparam int unsigned PW     = 274;
    localparam int unsigned SETTLE = 12;

    logic          CLK = 1'b0;
    logic          rst_n = 1'b0;
    logic [TW-1:0] time_i = '0;
    logic          time_upd_i = 1'b0;
    logic          clr_ovf_i = 1'b0;
    logic [2:0]    count_o;
    logic          full_o, ovf_o, busy_o;

    int n_chk  = 0;
    int n_pass = 0;

    timed_cmd_sched_if #(.TW(TW), .PW(PW)) bus ();

    timed_cmd_sched #(.DEPTH(DEPTH), .TW(TW), .PW(PW), .T_RESERVE(384)) dut (
        .CLK        (CLK),
        .rst_n      (rst_n),
        .time_i     (time_i),
        .time_upd_i (time_upd_i),
        .bus        (bus),
        .count_o    (count_o),
        .full_o     (full_o),
        .ovf_o      (ovf_o),
        .clr_ovf_i  (clr_ovf_i),
        .busy_o     (busy_o)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.wr_valid_i = 1'b0;
        bus.req_i = 1'b0;
        time_upd_i = 1'b0;
        clr_ovf_i = 1'b0;
        time_i = 64'd100;
        cycles(2);
        rst_n = 1'b1;
        cycles(1);
    endtask

    task automatic write_cmd(input logic [TW-1:0] t, input logic [PW-1:0] p);
        logic done;
        done = 1'b0;
        bus.wr_valid_i = 1'b1;
        bus.wr_time_i = t;
        bus.wr_payload_i = p;
        for (int k = 0; k < 40 && !done; k++) begin
            if (bus.wr_ready_o) done = 1'b1;
            @(negedge CLK);
        end
        bus.wr_valid_i = 1'b0;
        chk("write_accepted", 320'(done), 320'(1));
    endtask

    // Holds req_i until the strobe, then checks the handed-over command
    task automatic issue_req(input string tag, input logic [TW-1:0] et, input logic [PW-1:0] ep);
        logic seen;
        seen = 1'b0;
        bus.req_i = 1'b1;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(negedge CLK);
            if (bus.cmd_strobe_o) seen = 1'b1;
        end
        chk({tag, "_strobe"}, 320'(seen), 320'(1));
        chk({tag, "_time"}, 320'(bus.cmd_time_o), 320'(et));
        chk({tag, "_payload"}, 320'(bus.cmd_payload_o), 320'(ep));
        bus.req_i = 1'b0;
        @(negedge CLK);
        chk({tag, "_strobe_1cyc"}, 320'(bus.cmd_strobe_o), 320'(0));
        chk({tag, "_valid_drop"}, 320'(bus.cmd_valid_o), 320'(0));
    endtask

    task automatic pulse_upd();
        time_upd_i = 1'b1;
        @(negedge CLK);
        time_upd_i = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cmd_valid"}, 320'(bus.cmd_valid_o), 320'(0));
        chk({tag, "_strobe"}, 320'(bus.cmd_strobe_o), 320'(0));
        chk({tag, "_cmd_time"}, 320'(bus.cmd_time_o), 320'(0));
        chk({tag, "_cmd_payload"}, 320'(bus.cmd_payload_o), 320'(0));
        chk({tag, "_count"}, 320'(count_o), 320'(0));
        chk({tag, "_full"}, 320'(full_o), 320'(0));
        chk({tag, "_ovf"}, 320'(ovf_o), 320'(0));
        chk({tag, "_busy"}, 320'(busy_o), 320'(0));
    endtask

    initial begin
        logic          seen;
        logic [TW-1:0] issue_t;

        bus.wr_valid_i = 1'b0;
        bus.wr_time_i = '0;
        bus.wr_payload_i = '0;
        bus.req_i = 1'b0;
        time_i = 64'd100;
        cycles(2);
        chk_all_zero("reset");
        rst_n = 1'b1;
        cycles(1);

`ifndef TIMED_CMD_SCHED_AUTOISSUE_EN
        // Earliest future command is staged
        write_cmd(64'd500, PW'(1500));
        write_cmd(64'd300, PW'(900));
        write_cmd(64'd700, PW'(2100));
        cycles(SETTLE);
        chk("stage_valid", 320'(bus.cmd_valid_o), 320'(1));
        chk("stage_time", 320'(bus.cmd_time_o), 320'(300));
        chk("stage_payload", 320'(bus.cmd_payload_o), 320'(900));
        chk("stage_count", 320'(count_o), 320'(3));

        issue_req("issue300", 64'd300, PW'(900));
        cycles(SETTLE);
        chk("restage_time", 320'(bus.cmd_time_o), 320'(500));
        chk("restage_count", 320'(count_o), 320'(2));

        // Fill to DEPTH then overflow; set beats simultaneous clear
        write_cmd(64'd800, PW'(8));
        write_cmd(64'd900, PW'(9));
        cycles(SETTLE);
        chk("fill_count", 320'(count_o), 320'(4));
        chk("fill_full", 320'(full_o), 320'(1));
        bus.wr_valid_i = 1'b1;
        bus.wr_time_i = 64'd1234;
        clr_ovf_i = 1'b1;
        #1;
        chk("full_ready", 320'(bus.wr_ready_o), 320'(0));
        @(negedge CLK);
        bus.wr_valid_i = 1'b0;
        clr_ovf_i = 1'b0;
        chk("ovf_set_wins", 320'(ovf_o), 320'(1));
        cycles(2);
        chk("ovf_sticky", 320'(ovf_o), 320'(1));
        chk("ovf_count", 320'(count_o), 320'(4));
        clr_ovf_i = 1'b1;
        @(negedge CLK);
        clr_ovf_i = 1'b0;
        chk("ovf_clear", 320'(ovf_o), 320'(0));
        chk("full_stage_time", 320'(bus.cmd_time_o), 320'(500));

        // Stale entry purged after time update
        do_reset();
        write_cmd(64'd200, PW'(2));
        write_cmd(64'd900, PW'(90));
        cycles(SETTLE);
        chk("purge_pre_time", 320'(bus.cmd_time_o), 320'(200));
        chk("purge_pre_count", 320'(count_o), 320'(2));
        time_i = 64'd400;
        pulse_upd();
        cycles(SETTLE);
        chk("purge_count", 320'(count_o), 320'(1));
        chk("purge_time", 320'(bus.cmd_time_o), 320'(900));
        chk("purge_payload", 320'(bus.cmd_payload_o), 320'(90));
        chk("purge_valid", 320'(bus.cmd_valid_o), 320'(1));

        // Equal times resolve to the lower slot
        do_reset();
        write_cmd(64'd800, PW'(1));
        write_cmd(64'd600, PW'(11));
        write_cmd(64'd900, PW'(2));
        write_cmd(64'd600, PW'(33));
        cycles(SETTLE);
        chk("tie_first_payload", 320'(bus.cmd_payload_o), 320'(11));
        chk("tie_count", 320'(count_o), 320'(4));
        issue_req("tie_issue", 64'd600, PW'(11));
        cycles(SETTLE);
        chk("tie_second_time", 320'(bus.cmd_time_o), 320'(600));
        chk("tie_second_payload", 320'(bus.cmd_payload_o), 320'(33));
        chk("tie_second_count", 320'(count_o), 320'(3));
`else
        // Staged command leaves T_RESERVE ticks ahead of its start time
        write_cmd(64'd1000, PW'(77));
        cycles(SETTLE);
        chk("auto_stage_valid", 320'(bus.cmd_valid_o), 320'(1));
        chk("auto_stage_time", 320'(bus.cmd_time_o), 320'(1000));
        seen = 1'b0;
        issue_t = '0;
        for (int t = 600; t < 700 && !seen; t++) begin
            time_i = 64'(t);
            @(negedge CLK);
            if (bus.cmd_strobe_o) begin
                seen = 1'b1;
                issue_t = time_i;
                chk("auto_strobe_cmd_time", 320'(bus.cmd_time_o), 320'(1000));
            end
        end
        chk("auto_seen", 320'(seen), 320'(1));
        chk("auto_issue_time", 320'(issue_t), 320'(616));
        cycles(SETTLE);
        chk("auto_count", 320'(count_o), 320'(0));
        chk("auto_valid", 320'(bus.cmd_valid_o), 320'(0));
        write_cmd(64'd5000, PW'(5));
        write_cmd(64'd6000, PW'(6));
        cycles(SETTLE);
`endif

        // Reset in the middle of a scan
        pulse_upd();
        @(negedge CLK);
        chk("midscan_busy", 320'(busy_o), 320'(1));
        @(negedge CLK);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midscan_async");
        @(posedge CLK);
        #1;
        chk_all_zero("midscan_edge");
        @(negedge CLK);
        rst_n = 1'b1;
        cycles(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
